// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, the execute-stage redirect and IF/ID.
// master = fetch unit side, slave = the surrounding pipeline/memory side.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        misalign_fault;

    modport master (
        output imem_req, imem_addr, valid_out, pc_out, instruction_out, misalign_fault,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, ready_in
    );

    modport slave (
        input  imem_req, imem_addr, valid_out, pc_out, instruction_out, misalign_fault,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, ready_in
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads, queues {pc, instr} toward IF/ID, flushes on redirect.
// Define IFU_MISALIGN_CHECK_EN to halt issue and flag misalign_fault on a misaligned redirect target.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_unit_if.master ifu
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_q_pc    [DEPTH];
    logic [31:0] r_q_instr [DEPTH];
    ptr_t        r_rd_ptr;
    ptr_t        r_wr_ptr;
    cnt_t        r_count;
    logic [31:0] r_pcf     [DEPTH];
    ptr_t        r_pcf_rd;
    ptr_t        r_pcf_wr;
    cnt_t        r_outstanding;
    cnt_t        r_discard;
    logic [31:0] r_head_pc;
    logic [31:0] r_head_instr;

    logic        w_halted;
    logic [CW:0] w_inflight;
    logic        w_req;
    logic        w_grant;
    logic        w_rsp;
    logic        w_drop;
    logic        w_wr;
    logic        w_pop;
    ptr_t        w_rd_next;
    cnt_t        w_cnt_left;

    // Outstanding requests reserve queue slots, so a granted response always has room.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req      = !rst && !ifu.redirect_valid && !w_halted && (w_inflight < LIM);
    assign w_grant    = w_req && ifu.imem_gnt;
    assign w_rsp      = ifu.imem_rvalid && (r_outstanding != '0);
    assign w_drop     = ifu.redirect_valid || (r_discard != '0);
    assign w_wr       = w_rsp && !w_drop;
    assign w_pop      = (r_count != '0) && ifu.ready_in && !ifu.redirect_valid;
    assign w_rd_next  = r_rd_ptr + ptr_t'(w_pop);
    assign w_cnt_left = r_count - cnt_t'(w_pop);

    assign ifu.imem_req        = w_req;
    assign ifu.imem_addr       = r_fetch_pc;
    assign ifu.valid_out       = (r_count != '0);
    assign ifu.pc_out          = r_head_pc;
    assign ifu.instruction_out = r_head_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_q_pc        <= '{default: '0};
            r_q_instr     <= '{default: NOP};
            r_pcf         <= '{default: '0};
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_pcf_rd      <= '0;
            r_pcf_wr      <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_head_pc     <= '0;
            r_head_instr  <= NOP;
        end else begin
            // The PC FIFO advances on every response, including dropped ones, to stay paired.
            if (w_grant) begin
                r_pcf[r_pcf_wr] <= r_fetch_pc;
                r_pcf_wr        <= r_pcf_wr + ptr_t'(1);
            end
            if (w_rsp) begin
                r_pcf_rd <= r_pcf_rd + ptr_t'(1);
            end
            r_outstanding <= r_outstanding + cnt_t'(w_grant) - cnt_t'(w_rsp);

            if (ifu.redirect_valid) begin
                r_fetch_pc <= ifu.redirect_pc & ~32'h3;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_discard  <= r_outstanding - cnt_t'(w_rsp);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_wr) begin
                    r_q_pc[r_wr_ptr]    <= r_pcf[r_pcf_rd];
                    r_q_instr[r_wr_ptr] <= ifu.imem_rdata;
                    r_wr_ptr            <= r_wr_ptr + ptr_t'(1);
                end
                r_rd_ptr <= w_rd_next;
                r_count  <= w_cnt_left + cnt_t'(w_wr);
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - cnt_t'(1);
                end
                // Head registers track the post-update head; they hold when the queue drains.
                if (w_cnt_left != '0) begin
                    r_head_pc    <= r_q_pc[w_rd_next];
                    r_head_instr <= r_q_instr[w_rd_next];
                end else if (w_wr) begin
                    r_head_pc    <= r_pcf[r_pcf_rd];
                    r_head_instr <= ifu.imem_rdata;
                end
            end
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (ifu.redirect_valid) begin
            r_halted <= |ifu.redirect_pc[1:0];
        end
    end

    assign w_halted           = r_halted;
    assign ifu.misalign_fault = r_halted;
`else
    assign w_halted           = 1'b0;
    assign ifu.misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (DEPTH=2, RESET_PC=0x100) with an in-order memory model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    logic mem_hold;
    int   n_cmp;
    int   n_err;
    int   n_grant;
    logic [31:0] pend[$];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (bus)
    );

    typedef struct {
        logic        rst;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic rd, input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc, input logic [31:0] ins);
        vec_t t;
        t.rst = r; t.ready = rd; t.e_req = req; t.e_addr = addr;
        t.e_valid = v; t.e_pc = pc; t.e_instr = ins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        rst = r;
        bus.ready_in = rd;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: grant sampled mid-cycle, response presented in the following cycle unless held.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_hold && pend.size() > 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else if (bus.imem_req && bus.imem_gnt) begin
                pend.push_back(bus.imem_addr);
                n_grant++;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0; n_grant = 0;
        rst = 1'b1; mem_hold = 1'b0;
        bus.imem_gnt = 1'b1; bus.ready_in = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

        vecs[0]  = mk(1, 0, 0, 32'h100, 0, 32'h0,   NOP);
        vecs[1]  = mk(0, 0, 1, 32'h100, 0, 32'h0,   NOP);
        vecs[2]  = mk(0, 0, 1, 32'h104, 0, 32'h0,   NOP);
        for (int i = 3; i <= 10; i++)
            vecs[i] = mk(0, 0, 0, 32'h108, 1, 32'h100, mem_word(32'h100));
        vecs[11] = mk(0, 1, 0, 32'h108, 1, 32'h100, mem_word(32'h100));
        vecs[12] = mk(0, 1, 1, 32'h108, 1, 32'h104, mem_word(32'h104));
        vecs[13] = mk(0, 1, 1, 32'h10C, 0, 32'h104, mem_word(32'h104));
        vecs[14] = mk(0, 1, 0, 32'h110, 1, 32'h108, mem_word(32'h108));
        vecs[15] = mk(0, 1, 1, 32'h110, 1, 32'h10C, mem_word(32'h10C));

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].rst, vecs[i].ready, 1'b0, 32'h0);
            chk($sformatf("c%0d.req", i),   bus.imem_req,        vecs[i].e_req);
            chk($sformatf("c%0d.addr", i),  bus.imem_addr,       vecs[i].e_addr);
            chk($sformatf("c%0d.valid", i), bus.valid_out,       vecs[i].e_valid);
            chk($sformatf("c%0d.pc", i),    bus.pc_out,          vecs[i].e_pc);
            chk($sformatf("c%0d.instr", i), bus.instruction_out, vecs[i].e_instr);
            chk($sformatf("c%0d.fault", i), bus.misalign_fault,  1'b0);
            if (i == 10) chk("bp_grants", n_grant, 2);
        end

        // Redirect with two stale requests outstanding
        mem_hold = 1'b1;
        cyc(0, 1, 0, 32'h0);     chk("rd.req16", bus.imem_req, 1'b1); chk("rd.addr16", bus.imem_addr, 32'h114);
        cyc(0, 1, 1, 32'h2000);  chk("rd.req17", bus.imem_req, 1'b0);
        mem_hold = 1'b0;
        cyc(0, 1, 0, 32'h0);     chk("rd.valid18", bus.valid_out, 1'b0); chk("rd.req18", bus.imem_req, 1'b0);
        cyc(0, 1, 0, 32'h0);     chk("rd.valid19", bus.valid_out, 1'b0); chk("rd.addr19", bus.imem_addr, 32'h2000);
                                 chk("rd.req19", bus.imem_req, 1'b1);
        cyc(0, 1, 0, 32'h0);     chk("rd.valid20", bus.valid_out, 1'b0); chk("rd.addr20", bus.imem_addr, 32'h2004);

        // Redirect coincident with a response and a pop
        cyc(0, 1, 1, 32'h4000);  chk("co.valid21", bus.valid_out, 1'b1); chk("co.pc21", bus.pc_out, 32'h2000);
                                 chk("co.instr21", bus.instruction_out, mem_word(32'h2000));
        cyc(0, 0, 0, 32'h0);     chk("co.valid22", bus.valid_out, 1'b0); chk("co.addr22", bus.imem_addr, 32'h4000);
                                 chk("co.req22", bus.imem_req, 1'b1);
        cyc(0, 0, 0, 32'h0);     chk("co.valid23", bus.valid_out, 1'b0); chk("co.addr23", bus.imem_addr, 32'h4004);
        cyc(0, 0, 0, 32'h0);     chk("co.pc24", bus.pc_out, 32'h4000); chk("co.req24", bus.imem_req, 1'b0);
                                 chk("co.instr24", bus.instruction_out, mem_word(32'h4000));

        // Reset with the queue full, then restart
        cyc(1, 0, 0, 32'h0);     chk("rs.valid25", bus.valid_out, 1'b1); chk("rs.pc25", bus.pc_out, 32'h4000);
        cyc(0, 1, 0, 32'h0);     chk("rs.valid26", bus.valid_out, 1'b0); chk("rs.pc26", bus.pc_out, 32'h0);
                                 chk("rs.instr26", bus.instruction_out, NOP);
                                 chk("rs.addr26", bus.imem_addr, 32'h100); chk("rs.req26", bus.imem_req, 1'b1);
        cyc(0, 1, 0, 32'h0);     chk("rs.addr27", bus.imem_addr, 32'h104);
        cyc(0, 1, 0, 32'h0);     chk("rs.valid28", bus.valid_out, 1'b1); chk("rs.pc28", bus.pc_out, 32'h100);

        // Misaligned redirect target
        cyc(0, 1, 1, 32'h2002);  chk("ma.pc29", bus.pc_out, 32'h104); chk("ma.req29", bus.imem_req, 1'b0);
`ifdef IFU_MISALIGN_CHECK_EN
        cyc(0, 1, 0, 32'h0);     chk("ma.fault30", bus.misalign_fault, 1'b1); chk("ma.req30", bus.imem_req, 1'b0);
                                 chk("ma.valid30", bus.valid_out, 1'b0);
        cyc(0, 1, 1, 32'h3000);  chk("ma.fault31", bus.misalign_fault, 1'b1);
        cyc(0, 1, 0, 32'h0);     chk("ma.fault32", bus.misalign_fault, 1'b0); chk("ma.req32", bus.imem_req, 1'b1);
                                 chk("ma.addr32", bus.imem_addr, 32'h3000);
        cyc(0, 1, 0, 32'h0);     chk("ma.addr33", bus.imem_addr, 32'h3004);
        cyc(0, 1, 0, 32'h0);     chk("ma.valid34", bus.valid_out, 1'b1); chk("ma.pc34", bus.pc_out, 32'h3000);
                                 chk("ma.instr34", bus.instruction_out, mem_word(32'h3000));
`else
        cyc(0, 1, 0, 32'h0);     chk("ma.fault30", bus.misalign_fault, 1'b0); chk("ma.req30", bus.imem_req, 1'b1);
                                 chk("ma.addr30", bus.imem_addr, 32'h2000); chk("ma.valid30", bus.valid_out, 1'b0);
        cyc(0, 1, 0, 32'h0);     chk("ma.addr31", bus.imem_addr, 32'h2004);
        cyc(0, 1, 0, 32'h0);     chk("ma.valid32", bus.valid_out, 1'b1); chk("ma.pc32", bus.pc_out, 32'h2000);
                                 chk("ma.instr32", bus.instruction_out, mem_word(32'h2000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
